pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting caches (legal 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, physical address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 256, cache line width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port port_read  input  NUM_PORTS  per-port line read request, held until port_resp.
REQ-007 SHALL have port port_write  input  NUM_PORTS  per-port line write request, held until port_resp.
REQ-008 SHALL have port port_addr  input  NUM_PORTS*ADDR_WIDTH  per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port port_wdata  input  NUM_PORTS*LINE_WIDTH  per-port write line; port i at [i*LINE_WIDTH +: LINE_WIDTH].
REQ-010 SHALL have port port_rdata  output  NUM_PORTS*LINE_WIDTH  per-port read line, same packing.
REQ-011 SHALL have port port_resp  output  NUM_PORTS  one-cycle completion pulse per port.
REQ-012 SHALL have port pmem_read / pmem_write  output  1 each  physical memory request strobes.
REQ-013 SHALL have port pmem_address  output  ADDR_WIDTH  registered address of the granted port.
REQ-014 SHALL have port pmem_wdata  output  LINE_WIDTH  registered write line of the granted port.
REQ-015 SHALL have port pmem_rdata  input  LINE_WIDTH, and pmem_resp  input  1, memory return data and done.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RECOVER.
REQ-018 IDLE: when any port_read|port_write bit is high, SHALL pick a winner, register its index, op, address and wdata, and move to BUSY next edge; otherwise SHALL stay in IDLE.
REQ-019 BUSY: SHALL drive pmem_read or pmem_write (never both) from the registered op; pmem_address/pmem_wdata SHALL come only from registers.
REQ-020 Request-to-strobe latency SHALL be exactly 1 cycle (request sampled at edge N, strobe high after edge N+1).
REQ-021 On pmem_resp in BUSY: port_resp[grant] SHALL be high in the same cycle, port_rdata for grant SHALL equal pmem_rdata in that cycle, and the FSM SHALL move to RECOVER.
REQ-022 RECOVER: SHALL last exactly 1 cycle with no strobes and no arbitration, then return to IDLE.
REQ-023 port_rdata and port_resp of non-granted ports SHALL always be zero; all port_rdata SHALL be zero outside the response cycle.
REQ-024 Changes to port inputs while BUSY SHALL NOT affect the transaction in flight; a dropped request SHALL still receive port_resp.
REQ-025 A port asserting read and write together SHALL be treated as a write.
REQ-026 pmem_resp outside BUSY SHALL be ignored.
REQ-027 Without a pmem_resp, the FSM SHALL remain in BUSY indefinitely (no timeout).

Reset
REQ-028 While rst is high, the FSM SHALL enter IDLE immediately; all outputs, grant index and latched op/address/wdata SHALL be zero; the priority pointer SHALL be NUM_PORTS-1.
REQ-029 Reset during BUSY SHALL drop pmem_read/pmem_write without waiting for a clock edge and SHALL abandon the transaction with no port_resp.

Configuration
REQ-030 With PMEM_ARB_RR_EN defined: round-robin arbitration SHALL search from pointer+1 upward with wrap-around, and the pointer SHALL load the grant index when port_resp fires.
REQ-031 With PMEM_ARB_RR_EN undefined: fixed priority SHALL apply, lowest requesting index wins, and the pointer SHALL not exist.

Verification
REQ-032 Port 1 read 0x0000_1000 alone -> pmem_read high 1 cycle later with address 0x0000_1000; pmem_resp with rdata 0xA5..A5 -> port_resp[1]=1 and port 1 rdata=0xA5..A5 in that cycle; busy low 2 cycles after resp.
REQ-033 Ports 0 and 1 request continuously, RR_EN defined -> grant order 0,1,0,1; RR_EN undefined -> 0,0,0.
REQ-034 Port 0 write 0x40 with wdata 0x1234 while port 0 sets address to 0x80 in BUSY -> pmem_address stays 0x40 and pmem_wdata stays 0x1234 until resp.
REQ-035 rst pulsed mid-BUSY -> pmem_read falls before the next edge; no port_resp; next request is serviced starting from port 0.
REQ-036 NUM_PORTS=4, ports 1 and 3 request after grant of 3, RR_EN defined -> port 1 granted next (wrap-around).

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
// Arbitrates cache-line read/write requests from NUM_PORTS caches onto a
// single physical memory port. One transaction is in flight at a time:
// IDLE picks a winner and latches its op/address/wdata, BUSY holds the
// memory strobe until pmem_resp, and RECOVER inserts one dead cycle.
//
// Configuration macro: PMEM_ARB_RR_EN
//   defined   -> round-robin arbitration from a priority pointer
//   undefined -> fixed priority, lowest requesting index wins
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   port_read/port_write     per-port requests, held until port_resp
//   port_addr/port_wdata     per-port address / write line (packed by port)
//   port_rdata/port_resp     per-port read line / one-cycle completion pulse
//   pmem_read/pmem_write     memory strobes (combinational from state)
//   pmem_address/pmem_wdata  latched address / write line of the winner
//   pmem_rdata/pmem_resp     memory return data / done
//   busy                     high whenever the FSM is not IDLE
module pmem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_read,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS*LINE_WIDTH-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]            port_resp,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [ADDR_WIDTH-1:0]           pmem_address,
  output logic [LINE_WIDTH-1:0]           pmem_wdata,
  input  logic [LINE_WIDTH-1:0]           pmem_rdata,
  input  logic                            pmem_resp,
  output logic                            busy
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

  logic [NUM_PORTS-1:0]    req;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_vld;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [LINE_WIDTH-1:0]   wdata_sel;
  logic                    wr_sel;
  logic                    resp_fire;

  assign req       = port_read | port_write;
  assign resp_fire = (state_q == BUSY) && pmem_resp;

`ifdef PMEM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // Search starts one past the last serviced port and wraps around.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_PORTS);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (resp_fire) ptr_d = grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IDX_W'(NUM_PORTS - 1);
    else     ptr_q <= ptr_d;
  end
`else
  // Descending scan so the lowest requesting index is the last to assign.
  always_comb begin
    win_idx = '0;
    win_vld = |req;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  // Winner's request fields; a simultaneous read+write counts as a write.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    wr_sel    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == IDX_W'(i)) begin
        addr_sel  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_sel = port_wdata[i*LINE_WIDTH +: LINE_WIDTH];
        wr_sel    = port_write[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d    = BUSY;
          grant_d    = win_idx;
          op_write_d = wr_sel;
          addr_d     = addr_sel;
          wdata_d    = wdata_sel;
        end
      end
      BUSY:    if (pmem_resp) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  assign pmem_read    = (state_q == BUSY) && !op_write_q;
  assign pmem_write   = (state_q == BUSY) &&  op_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    port_resp  = '0;
    port_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (resp_fire && grant_q == IDX_W'(i)) begin
        port_resp[i]                          = 1'b1;
        port_rdata[i*LINE_WIDTH +: LINE_WIDTH] = pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
// Directed bench for pmem_arbiter with four ports. Expected grants follow
// round-robin when PMEM_ARB_RR_EN is defined, fixed priority otherwise.
module tb_pmem_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 256;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      port_read, port_write;
  logic [NP*AW-1:0]   port_addr;
  logic [NP*LW-1:0]   port_wdata;
  logic [NP*LW-1:0]   port_rdata;
  logic [NP-1:0]      port_resp;
  logic               pmem_read, pmem_write;
  logic [AW-1:0]      pmem_address;
  logic [LW-1:0]      pmem_wdata;
  logic [LW-1:0]      pmem_rdata;
  logic               pmem_resp;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] addr_tab [NP];
  int t2_exp [4];
  int t4c_exp;

  pmem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .port_read(port_read), .port_write(port_write),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_resp(port_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE; requests are left asserted for the caller.
  task automatic txn(input logic [NP-1:0] rd, input logic [NP-1:0] wr,
                     input int exp, input logic [LW-1:0] pat, input string tag);
    logic [NP*LW-1:0] e_rdata;
    logic [1:0]       e_strb;
    e_rdata = '0;
    e_rdata[exp*LW +: LW] = pat;
    e_strb = wr[exp[1:0]] ? 2'b01 : 2'b10;
    port_read  = rd;
    port_write = wr;
    #1;
    check({tag, "_pre_strobe"}, {pmem_read, pmem_write}, 2'b00);
    tick;
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_strobe"}, {pmem_read, pmem_write}, e_strb);
    check({tag, "_addr"}, pmem_address, addr_tab[exp]);
    check({tag, "_no_early_resp"}, port_resp, '0);
    pmem_rdata = pat;
    pmem_resp  = 1'b1;
    #1;
    check({tag, "_resp"}, port_resp, NP'(1) << exp);
    check({tag, "_rdata"}, port_rdata, e_rdata);
    tick;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    check({tag, "_recover_busy"}, busy, 1'b1);
    check({tag, "_recover_strobe"}, {pmem_read, pmem_write}, 2'b00);
    tick;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PMEM_ARB_RR_EN
    t2_exp  = '{0, 1, 0, 1};
    t4c_exp = 3;
`else
    t2_exp  = '{0, 0, 0, 0};
    t4c_exp = 1;
`endif
    addr_tab = '{32'h0000_0800, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    for (int i = 0; i < NP; i++) port_addr[i*AW +: AW] = addr_tab[i];
    port_wdata = '0;
    port_read  = '0;
    port_write = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    rst        = 1'b1;
    tick;
    tick;
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", {pmem_read, pmem_write}, 2'b00);
    check("rst_addr", pmem_address, '0);
    check("rst_wdata", pmem_wdata, '0);
    check("rst_resp", port_resp, '0);
    rst = 1'b0;

    // Single read on port 1.
    txn(4'b0010, 4'b0000, 1, {8{32'hA5A5_A5A5}}, "t1");
    port_read = '0;

    // Stray pmem_resp while idle.
    pmem_resp = 1'b1;
    pmem_rdata = {8{32'h5A5A_5A5A}};
    #1;
    check("idle_resp_ignored", port_resp, '0);
    check("idle_rdata_zero", port_rdata, '0);
    tick;
    check("idle_resp_no_busy", busy, 1'b0);
    pmem_resp = 1'b0;
    pmem_rdata = '0;

    // Ports 0 and 1 requesting continuously.
    for (int n = 0; n < 4; n++)
      txn(4'b0011, 4'b0000, t2_exp[n], {8{n[7:0], 24'h00C0DE}}, $sformatf("t2_%0d", n));
    port_read = '0;

    // Port 0 read+write (treated as write), inputs change and drop mid-flight.
    port_addr[0 +: AW]  = 32'h0000_0040;
    port_wdata[0 +: LW] = 256'h1234;
    port_read  = 4'b0001;
    port_write = 4'b0001;
    tick;
    check("t3_strobe", {pmem_read, pmem_write}, 2'b01);
    check("t3_addr", pmem_address, 32'h40);
    check("t3_wdata", pmem_wdata, 256'h1234);
    port_addr[0 +: AW]  = 32'h0000_0080;
    port_wdata[0 +: LW] = 256'h5678;
    port_read  = '0;
    port_write = '0;
    for (int n = 0; n < 3; n++) begin
      tick;
      check("t3_hold_busy", busy, 1'b1);
      check("t3_hold_addr", pmem_address, 32'h40);
      check("t3_hold_wdata", pmem_wdata, 256'h1234);
    end
    pmem_resp = 1'b1;
    #1;
    check("t3_resp_dropped", port_resp, 4'b0001);
    tick;
    pmem_resp = 1'b0;
    tick;
    check("t3_idle", busy, 1'b0);
    port_addr[0 +: AW]  = addr_tab[0];
    port_wdata[0 +: LW] = '0;

    // Wrap-around after a grant of port 3.
    txn(4'b1000, 4'b0000, 3, {8{32'h3333_0003}}, "t4a");
    txn(4'b1010, 4'b0000, 1, {8{32'h1111_0001}}, "t4b");
    txn(4'b1010, 4'b0000, t4c_exp, {8{32'hCCCC_000C}}, "t4c");
    txn(4'b0110, 4'b0000, 1, {8{32'hDDDD_000D}}, "t4d");
    port_read = '0;

    // Reset in the middle of a port 2 read.
    port_read = 4'b0100;
    tick;
    check("t5_strobe", {pmem_read, pmem_write}, 2'b10);
    #2;
    rst = 1'b1;
    pmem_resp = 1'b1;
    #1;
    check("t5_rst_strobe", {pmem_read, pmem_write}, 2'b00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_resp", port_resp, '0);
    check("t5_rst_addr", pmem_address, '0);
    tick;
    rst = 1'b0;
    pmem_resp = 1'b0;
    port_read = '0;
    #1;
    txn(4'b0101, 4'b0000, 0, {8{32'hEEEE_000E}}, "t5_after");
    port_read = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
